// File: rtl/pc_fetch_sequencer_if.sv
// Instruction-memory fetch handshake between the PC sequencer and imem.
// master: drives imem_req/imem_addr, samples imem_ready; slave: memory side.
interface pc_fetch_sequencer_if #(
    parameter int PC_W = 9
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready
    );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// IF-stage PC owner and fetch sequencer: redirects, halt, fault, flush.
// Ports: clk, reset (async low), PcSel/BrPC/Halt, Stall, imem (master), Cur_PC, if_valid, flush, halted, fault.
module pc_fetch_sequencer #(
    parameter int PC_W = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  PcSel,
    input  logic [31:0]           BrPC,
    input  logic                  Halt,
    input  logic                  Stall,
    pc_fetch_sequencer_if.master  imem,
    output logic [PC_W-1:0]       Cur_PC,
    output logic                  if_valid,
    output logic                  flush,
    output logic                  halted,
    output logic                  fault
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2,
        FAULT  = 2'd3
    } state_t;

    state_t          state;
    logic            pend;
    logic [PC_W-1:0] pend_pc;
    logic            fetching;
    logic            illegal;
    logic [PC_W-1:0] target;

    assign fetching = (state == FETCH);
    assign target   = BrPC[PC_W-1:0];
    assign illegal  = (BrPC[1:0] != 2'b00) || (BrPC[31:PC_W] != '0);

    assign imem.imem_req  = fetching;
    assign imem.imem_addr = fetching ? Cur_PC : '0;
    assign flush          = fetching && PcSel;
    // Dropped whenever the PC is about to move elsewhere or is frozen.
    assign if_valid       = fetching && imem.imem_ready && !Stall
                            && !pend && !PcSel;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            Cur_PC  <= '0;
            pend    <= 1'b0;
            pend_pc <= '0;
            halted  <= 1'b0;
            fault   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    state <= FETCH;
                end
                FETCH: begin
                    if (PcSel && Halt) begin
                        Cur_PC <= target;
                        state  <= HALTED;
                        halted <= 1'b1;
                        pend   <= 1'b0;
                    end else if (PcSel && illegal) begin
                        state <= FAULT;
                        fault <= 1'b1;
                        pend  <= 1'b0;
                    end else if (PcSel) begin
                        // A fetch still waiting on imem keeps its address;
                        // the target is parked until that response lands.
                        if (imem.imem_ready) begin
                            Cur_PC <= target;
                            pend   <= 1'b0;
                        end else begin
                            pend_pc <= target;
                            pend    <= 1'b1;
                        end
                    end else if (pend) begin
                        if (imem.imem_ready) begin
                            Cur_PC <= pend_pc;
                            pend   <= 1'b0;
                        end
                    end else if (!Stall && imem.imem_ready) begin
                        Cur_PC <= Cur_PC + PC_W'(4);
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                FAULT: begin
                    state <= FAULT;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Scoreboard bench for pc_fetch_sequencer: directed plan plus random traffic.
// Expected per-cycle outputs and accepted fetch addresses are queued and checked by a monitor.
module tb_pc_fetch_sequencer;

    localparam int PC_W = 9;
    localparam int MEM  = 1 << PC_W;

    logic            clk;
    logic            reset;
    logic            PcSel;
    logic [31:0]     BrPC;
    logic            Halt;
    logic            Stall;
    logic [PC_W-1:0] Cur_PC;
    logic            if_valid;
    logic            flush;
    logic            halted;
    logic            fault;

    pc_fetch_sequencer_if #(.PC_W(PC_W)) bus ();

    pc_fetch_sequencer #(.PC_W(PC_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .PcSel    (PcSel),
        .BrPC     (BrPC),
        .Halt     (Halt),
        .Stall    (Stall),
        .imem     (bus),
        .Cur_PC   (Cur_PC),
        .if_valid (if_valid),
        .flush    (flush),
        .halted   (halted),
        .fault    (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit req;
        int addr;
        bit valid;
        bit flsh;
        int pc;
        bit hlt;
        bit flt;
    } exp_t;

    exp_t q[$];
    int   fq[$];

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: "running" means the sequencer is issuing fetches.
    bit m_started;
    bit m_running;
    bit m_halted;
    bit m_fault;
    int m_pc;
    bit m_pend;
    int m_tgt;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     nm, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_started = 0;
        m_running = 0;
        m_halted  = 0;
        m_fault   = 0;
        m_pc      = 0;
        m_pend    = 0;
        m_tgt     = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #3;
        reset = 1'b0;
        PcSel = 1'b0;
        BrPC  = '0;
        Halt  = 1'b0;
        Stall = 1'b0;
        bus.imem_ready = 1'b0;
        #1;
        chk("reset_pc",     32'(Cur_PC),        0);
        chk("reset_req",    32'(bus.imem_req),  0);
        chk("reset_addr",   32'(bus.imem_addr), 0);
        chk("reset_valid",  32'(if_valid),      0);
        chk("reset_flush",  32'(flush),         0);
        chk("reset_halted", 32'(halted),        0);
        chk("reset_fault",  32'(fault),         0);
        model_reset();
        @(posedge clk);
        #3;
        reset = 1'b1;
    endtask

    task automatic cycle(input bit ps, input logic [31:0] br, input bit hl,
                         input bit st, input bit rd);
        exp_t e;
        bit   bad;
        @(negedge clk);
        PcSel = ps;
        BrPC  = br;
        Halt  = hl;
        Stall = st;
        bus.imem_ready = rd;

        e.pc  = m_pc;
        e.hlt = m_halted;
        e.flt = m_fault;
        if (m_running) begin
            e.req   = 1;
            e.addr  = m_pc;
            e.flsh  = ps;
            e.valid = rd && !st && !m_pend && !ps;
        end else begin
            e.req   = 0;
            e.addr  = 0;
            e.flsh  = 0;
            e.valid = 0;
        end
        if (e.valid) fq.push_back(m_pc);
        q.push_back(e);

        bad = (br % 4 != 0) || (br >= 32'(MEM));
        if (!m_started) begin
            m_started = 1;
            m_running = 1;
        end else if (m_running) begin
            if (ps && hl) begin
                m_pc      = int'(br % MEM);
                m_halted  = 1;
                m_running = 0;
                m_pend    = 0;
            end else if (ps && bad) begin
                m_fault   = 1;
                m_running = 0;
                m_pend    = 0;
            end else if (ps) begin
                if (rd) begin
                    m_pc   = int'(br);
                    m_pend = 0;
                end else begin
                    m_tgt  = int'(br);
                    m_pend = 1;
                end
            end else if (m_pend) begin
                if (rd) begin
                    m_pc   = m_tgt;
                    m_pend = 0;
                end
            end else if (!st && rd) begin
                m_pc = (m_pc + 4) % MEM;
            end
        end
    endtask

    // Monitor: compares outputs once inputs have settled each cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("imem_req",  32'(bus.imem_req),  32'(e.req));
                chk("imem_addr", 32'(bus.imem_addr), 32'(e.addr));
                chk("if_valid",  32'(if_valid),      32'(e.valid));
                chk("flush",     32'(flush),         32'(e.flsh));
                chk("cur_pc",    32'(Cur_PC),        32'(e.pc));
                chk("halted",    32'(halted),        32'(e.hlt));
                chk("fault",     32'(fault),         32'(e.flt));
                if (if_valid === 1'b1) begin
                    if (fq.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL fetch_accept: got 0x%0h expected none",
                                 bus.imem_addr);
                    end else begin
                        chk("fetch_accept", 32'(bus.imem_addr),
                            32'(fq.pop_front()));
                    end
                end
            end
        end
    end

    function automatic logic [31:0] legal_tgt();
        return {23'd0, 7'($urandom_range(0, 127)), 2'b00};
    endfunction

    function automatic logic [31:0] illegal_tgt();
        logic [31:0] v;
        v = $urandom;
        if ($urandom_range(0, 1) == 0) v = {23'd0, v[8:2], 2'b10};
        else v[31:PC_W] = 23'($urandom_range(1, 255));
        return v;
    endfunction

    initial begin
        reset = 1'b0;
        PcSel = 1'b0;
        BrPC  = '0;
        Halt  = 1'b0;
        Stall = 1'b0;
        bus.imem_ready = 1'b0;
        model_reset();

        // Zero-wait streaming with PC wrap.
        do_reset();
        for (int i = 0; i < 132; i++) cycle(0, 0, 0, 0, 1);

        // Redirect with no outstanding fetch.
        cycle(1, 32'h40, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);

        // Redirect while a fetch at 0x10 is waiting.
        cycle(1, 32'h10, 0, 0, 1);
        cycle(0, 0, 0, 0, 0);
        cycle(1, 32'h80, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);

        // Stall at 0x20.
        cycle(1, 32'h20, 0, 0, 1);
        cycle(0, 0, 0, 1, 1);
        cycle(0, 0, 0, 1, 1);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);

        // Halt, then ignored traffic.
        cycle(1, 32'h30, 1, 0, 1);
        for (int i = 0; i < 4; i++) cycle(1, 32'h44, i[0], 0, 1);
        do_reset();

        // Misaligned and out-of-range redirects.
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1);
        cycle(1, 32'h42, 0, 0, 1);
        for (int i = 0; i < 3; i++) cycle(1, 32'h30, 1, 0, 1);
        do_reset();
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1);
        cycle(1, 32'h200, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        do_reset();

        // Random traffic in short episodes.
        for (int ep = 0; ep < 25; ep++) begin
            for (int c = 0; c < 60; c++) begin
                bit          ps;
                bit          hl;
                logic [31:0] br;
                ps = ($urandom_range(0, 9) == 0);
                hl = ps && ($urandom_range(0, 11) == 0);
                br = ($urandom_range(0, 9) == 0) ? illegal_tgt() : legal_tgt();
                cycle(ps, br, hl, $urandom_range(0, 4) == 0,
                      $urandom_range(0, 2) != 0);
            end
            do_reset();
        end

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", 32'(q.size()),  0);
        chk("fetch_drained", 32'(fq.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_fetch_sequencer.md
# pc_fetch_sequencer

Program-counter owner and instruction-fetch sequencer for the IF stage. It consumes the redirect request from the branch unit (`PcSel`, `BrPC`, `Halt`) and the hazard unit's `Stall`. It holds the PC register, drives a request/ready handshake to instruction memory and marks which returned instructions may enter IF/ID. It also handles halt and fault states and generates the pipeline flush pulse on redirects.

## Interface
- `PC_W`, 9, width of PC and instruction-memory byte address

- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `PcSel`  in  1  redirect request from branch unit (EX stage)
- `BrPC`  in  32  redirect target; for halt, the address of the halting instruction
- `Halt`  in  1  qualifies `PcSel` as a halt redirect
- `Stall`  in  1  hazard-unit freeze of PC and IF/ID
- `imem_ready`  in  1  instruction memory returns data for `imem_addr` this cycle
- `imem_req`  out  1  fetch request
- `imem_addr`  out  PC_W  fetch byte address
- `Cur_PC`  out  PC_W  current PC register
- `if_valid`  out  1  fetched instruction may be written into IF/ID this cycle
- `flush`  out  1  one-cycle kill of IF/ID and ID/EX contents
- `halted`  out  1  core halted
- `fault`  out  1  sticky illegal-redirect flag

## Operation
- States: IDLE, FETCH, HALTED, FAULT. Reset enters IDLE.
- IDLE always moves to FETCH on the next edge.
- FETCH: `imem_req`=1 and `imem_addr`=`Cur_PC`.
  - Address must stay stable while `imem_req && !imem_ready`.
  - A fetch with `imem_req && !imem_ready` is outstanding.
- Event priority each FETCH cycle, highest first: halt redirect, illegal redirect, legal redirect, stall, sequential.
- Halt redirect (`PcSel && Halt`):
  - PC ← `BrPC[PC_W-1:0]`; go to HALTED.
  - `flush`=1; any outstanding fetch is discarded.
  - Pending redirect is cleared.
- Illegal redirect: `PcSel && !Halt` with `BrPC[1:0]!=0` or `BrPC[31:PC_W]!=0`.
  - Go to FAULT; `fault`←1; `flush`=1; PC unchanged.
- Legal redirect with no outstanding fetch, or with `imem_ready`=1 this cycle:
  - PC ← `BrPC[PC_W-1:0]`; `flush`=1; `if_valid`=0.
- Legal redirect with an outstanding fetch:
  - `pend_pc` ← target, `pend`←1; `flush`=1.
  - `imem_addr` stays on the old address until `imem_ready`.
  - That response is dropped (`if_valid`=0) and PC ← `pend_pc`, `pend`←0.
  - A further redirect while `pend`=1 overwrites `pend_pc` (last wins).
- Stall (no redirect): PC holds; `if_valid`=0. The handshake still completes, but the data is discarded and refetched.
- Sequential: when `imem_ready && !Stall && !pend && !PcSel`:
  - `if_valid`=1.
  - PC ← PC+4, modulo 2^PC_W (0x1FC wraps to 0x000 for PC_W=9).
- HALTED: `imem_req`=0, `halted`=1; all inputs ignored until reset.
- FAULT: `imem_req`=0, `fault`=1; all inputs ignored, including `Halt`, until reset.
- `PcSel` in IDLE is ignored.

## Timing
- Reset values: `Cur_PC`=0, `imem_req`=0, `imem_addr`=0, `if_valid`=0, `flush`=0, `halted`=0, `fault`=0, `pend`=0, `pend_pc`=0.
- Reset assertion mid-operation clears all state immediately, asynchronously, including a pending redirect.
- First edge after reset release: IDLE→FETCH. `imem_req` rises in the following cycle with address 0.
- `imem_req`, `imem_addr`, `if_valid` and `flush` are combinational from state and inputs.
- `Cur_PC`, `pend`, `halted` and `fault` are registered.
- Redirect latency:
  - With no outstanding fetch, the target is on `imem_addr` the cycle after `PcSel`.
  - With an outstanding fetch, the target appears the cycle after the old fetch's `imem_ready`.
- `flush` is high exactly in the cycle `PcSel` is sampled in FETCH, and never in any other cycle.
- Zero-wait memory (`imem_ready` tied 1, no stall): one instruction per cycle.

## Test plan
- Release reset, `imem_ready`=1 → `imem_addr` 0x000, 0x004, 0x008… with `if_valid`=1 every cycle; `Cur_PC` wraps from 0x1FC to 0x000.
- `PcSel`=1, `BrPC`=0x40 with no outstanding fetch → `flush`=1 for one cycle, `if_valid`=0, and next `imem_addr`=0x040.
- `imem_ready` low for 3 cycles at address 0x10, then `PcSel` (`BrPC`=0x80) in the second wait cycle:
  - `imem_addr` stays 0x010 until ready.
  - That response gives `if_valid`=0.
  - Next `imem_addr`=0x080.
- `Stall`=1 for 2 cycles at PC 0x20 → `Cur_PC` holds 0x020 and `if_valid`=0; fetch resumes at 0x020, then 0x024.
- `PcSel`=1, `Halt`=1, `BrPC`=0x30 → `Cur_PC`=0x030, `halted`=1 and `imem_req`=0 permanently. A later `PcSel` has no effect; reset returns to PC 0.
- `PcSel`=1 with `BrPC`=0x42, then separately with `BrPC`=0x200 → `fault`=1 and `imem_req`=0 for both; `Cur_PC` unchanged. Reset asserted mid-FAULT clears `fault`.
